// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the M-stage LSU and the data memory.
// Ports: master drives req/we/addr/wdata/wstrb; slave returns gnt/rvalid/rdata.
interface mem_stage_lsu_if;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_wstrb;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;

   modport master (
      output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
      input  dm_gnt, dm_rvalid, dm_rdata
   );

   modport slave (
      input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
      output dm_gnt, dm_rvalid, dm_rdata
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: req/gnt/rvalid memory handshake, stall, load extend.
// Ports: clk, rst (sync active-low), m_* M-stage inputs, dm (bus master),
//        lsu_stall, wb_valid, wb_load_data, misalign, bus_err.
module mem_stage_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m_valid,
   input  logic        m_mem_read,
   input  logic        m_mem_write,
   input  logic [2:0]  m_funct3,
   input  logic [31:0] m_alu_out,
   input  logic [31:0] m_rs2_data,
   mem_stage_lsu_if.master dm,
   output logic        lsu_stall,
   output logic        wb_valid,
   output logic [31:0] wb_load_data,
   output logic        misalign,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   localparam logic [7:0] TMO = TIMEOUT_CYCLES[7:0];

   state_t      state_q, state_d;
   logic [29:0] addr_q;
   logic [1:0]  off_q;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [7:0]  cnt_q;
   logic        err_q;
   logic [31:0] ld_q;

   logic        mem_op, sz_byte, sz_half, bad_addr, start;
   logic [31:0] wdata_n;
   logic [3:0]  wstrb_n;
   logic [7:0]  cnt_nxt;
   logic        tmo, to_abort, ld_take;
   logic        in_req, in_wait;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] ld_ext;

   // Size comes from funct3[1:0] so BU/HU share the B/H alignment rules
   // and every undefined code falls through to word.
   assign mem_op  = m_valid & (m_mem_read | m_mem_write);
   assign sz_byte = (m_funct3[1:0] == 2'b00);
   assign sz_half = (m_funct3[1:0] == 2'b01);

   always_comb begin
      bad_addr = 1'b0;
      unique case (1'b1)
         sz_byte: bad_addr = 1'b0;
         sz_half: bad_addr = m_alu_out[0];
         default: bad_addr = |m_alu_out[1:0];
      endcase
   end

   assign misalign = (state_q == IDLE) & mem_op & bad_addr;
   assign start    = (state_q == IDLE) & mem_op & ~bad_addr;

   always_comb begin
      wdata_n = m_rs2_data;
      wstrb_n = 4'b1111;
      unique case (1'b1)
         sz_byte: begin
            wdata_n = {4{m_rs2_data[7:0]}};
            wstrb_n = 4'b0001 << m_alu_out[1:0];
         end
         sz_half: begin
            wdata_n = {2{m_rs2_data[15:0]}};
            wstrb_n = m_alu_out[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wdata_n = m_rs2_data;
            wstrb_n = 4'b1111;
         end
      endcase
   end

   assign in_req  = (state_q == REQ);
   assign in_wait = (state_q == WAIT);
   assign cnt_nxt = cnt_q + 8'd1;
   assign tmo     = (cnt_nxt == TMO);

   assign lane_b = dm.dm_rdata[{off_q, 3'b000} +: 8];
   assign lane_h = dm.dm_rdata[{off_q[1], 4'b0000} +: 16];

   always_comb begin
      ld_ext = dm.dm_rdata;
      case (f3_q)
         3'b000:  ld_ext = {{24{lane_b[7]}}, lane_b};
         3'b100:  ld_ext = {24'd0, lane_b};
         3'b001:  ld_ext = {{16{lane_h[15]}}, lane_h};
         3'b101:  ld_ext = {16'd0, lane_h};
         default: ld_ext = dm.dm_rdata;
      endcase
   end

   // A granted store completes even on the last budget cycle; a load
   // granted that late is aborted, since its data could never arrive in time.
   always_comb begin
      state_d  = state_q;
      to_abort = 1'b0;
      ld_take  = 1'b0;
      unique case (state_q)
         IDLE: if (start) state_d = REQ;
         REQ: begin
            if (dm.dm_gnt && we_q) begin
               state_d = DONE;
            end else if (tmo) begin
               state_d  = DONE;
               to_abort = 1'b1;
            end else if (dm.dm_gnt) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (dm.dm_rvalid) begin
               state_d = DONE;
               ld_take = 1'b1;
            end else if (tmo) begin
               state_d  = DONE;
               to_abort = 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         off_q   <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         ld_q    <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= to_abort;
         if (start) begin
            addr_q  <= m_alu_out[31:2];
            off_q   <= m_alu_out[1:0];
            we_q    <= m_mem_write;
            f3_q    <= m_funct3;
            wdata_q <= m_mem_write ? wdata_n : 32'd0;
            wstrb_q <= m_mem_write ? wstrb_n : 4'b0000;
            cnt_q   <= '0;
         end else if (in_req || in_wait) begin
            cnt_q <= cnt_nxt;
         end
         if (ld_take) begin
            ld_q <= ld_ext;
         end else if (to_abort && !we_q) begin
            ld_q <= '0;
         end
      end
   end

   // Bus fields are only driven while a request is open.
   assign dm.dm_req   = in_req;
   assign dm.dm_we    = in_req & we_q;
   assign dm.dm_addr  = in_req ? {addr_q, 2'b00} : 32'd0;
   assign dm.dm_wdata = in_req ? wdata_q : 32'd0;
   assign dm.dm_wstrb = in_req ? wstrb_q : 4'b0000;

   assign lsu_stall    = start | in_req | in_wait;
   assign wb_valid     = (state_q == DONE);
   assign bus_err      = (state_q == DONE) & err_q;
   assign wb_load_data = ld_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: stores, loads, misalign, timeout, reset.
// A second instance with a 4-cycle budget covers the timeout path.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        m_valid, m_valid_t;
   logic        m_mem_read, m_mem_write;
   logic [2:0]  m_funct3;
   logic [31:0] m_alu_out, m_rs2_data;

   logic        lsu_stall, wb_valid, misalign, bus_err;
   logic [31:0] wb_load_data;
   logic        t_stall, t_valid, t_mis, t_err;
   logic [31:0] t_data;

   int n_cmp = 0;
   int n_err = 0;

   mem_stage_lsu_if bus ();
   mem_stage_lsu_if bus_t ();

   mem_stage_lsu dut (
      .clk          (clk),
      .rst          (rst),
      .m_valid      (m_valid),
      .m_mem_read   (m_mem_read),
      .m_mem_write  (m_mem_write),
      .m_funct3     (m_funct3),
      .m_alu_out    (m_alu_out),
      .m_rs2_data   (m_rs2_data),
      .dm           (bus),
      .lsu_stall    (lsu_stall),
      .wb_valid     (wb_valid),
      .wb_load_data (wb_load_data),
      .misalign     (misalign),
      .bus_err      (bus_err)
   );

   mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut_t (
      .clk          (clk),
      .rst          (rst),
      .m_valid      (m_valid_t),
      .m_mem_read   (m_mem_read),
      .m_mem_write  (m_mem_write),
      .m_funct3     (m_funct3),
      .m_alu_out    (m_alu_out),
      .m_rs2_data   (m_rs2_data),
      .dm           (bus_t),
      .lsu_stall    (t_stall),
      .wb_valid     (t_valid),
      .wb_load_data (t_data),
      .misalign     (t_mis),
      .bus_err      (t_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store_op(input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] ewd,
                           input logic [3:0] ews, input string tag);
      m_valid = 1'b1; m_mem_write = 1'b1; m_mem_read = 1'b0;
      m_funct3 = f3; m_alu_out = a; m_rs2_data = d;
      bus.dm_gnt = 1'b1;
      @(negedge clk);
      check({tag, "_c0_stall"}, 32'(lsu_stall), 32'd1);
      check({tag, "_c0_req"}, 32'(bus.dm_req), 32'd0);
      tick();
      @(negedge clk);
      check({tag, "_req"}, 32'(bus.dm_req), 32'd1);
      check({tag, "_we"}, 32'(bus.dm_we), 32'd1);
      check({tag, "_addr"}, bus.dm_addr, {a[31:2], 2'b00});
      check({tag, "_wdata"}, bus.dm_wdata, ewd);
      check({tag, "_wstrb"}, 32'(bus.dm_wstrb), 32'(ews));
      check({tag, "_c1_stall"}, 32'(lsu_stall), 32'd1);
      tick();
      @(negedge clk);
      check({tag, "_wbv"}, 32'(wb_valid), 32'd1);
      check({tag, "_c2_stall"}, 32'(lsu_stall), 32'd0);
      check({tag, "_c2_req"}, 32'(bus.dm_req), 32'd0);
      check({tag, "_berr"}, 32'(bus_err), 32'd0);
      tick();
      m_valid = 1'b0; m_mem_write = 1'b0; bus.dm_gnt = 1'b0;
      @(negedge clk);
      check({tag, "_wbv_pulse"}, 32'(wb_valid), 32'd0);
      tick();
   endtask

   // Three grant-free REQ cycles, then grant with a decoy rvalid that
   // must be ignored, then the real data in WAIT.
   task automatic load_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rd, input logic [31:0] exp,
                          input string tag);
      m_valid = 1'b1; m_mem_read = 1'b1; m_mem_write = 1'b0;
      m_funct3 = f3; m_alu_out = a; bus.dm_gnt = 1'b0;
      @(negedge clk);
      check({tag, "_c0_stall"}, 32'(lsu_stall), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         check({tag, "_hold_req"}, 32'(bus.dm_req), 32'd1);
         check({tag, "_hold_addr"}, bus.dm_addr, {a[31:2], 2'b00});
         check({tag, "_hold_wstrb"}, 32'(bus.dm_wstrb), 32'd0);
      end
      tick();
      bus.dm_gnt = 1'b1; bus.dm_rvalid = 1'b1;
      bus.dm_rdata = 32'h7F7F7F7F;
      @(negedge clk);
      check({tag, "_gnt_req"}, 32'(bus.dm_req), 32'd1);
      tick();
      bus.dm_gnt = 1'b0; bus.dm_rvalid = 1'b1; bus.dm_rdata = rd;
      @(negedge clk);
      check({tag, "_wait_stall"}, 32'(lsu_stall), 32'd1);
      check({tag, "_wait_req"}, 32'(bus.dm_req), 32'd0);
      tick();
      bus.dm_rvalid = 1'b0;
      @(negedge clk);
      check({tag, "_wbv"}, 32'(wb_valid), 32'd1);
      check({tag, "_data"}, wb_load_data, exp);
      check({tag, "_done_stall"}, 32'(lsu_stall), 32'd0);
      tick();
      m_valid = 1'b0; m_mem_read = 1'b0;
      @(negedge clk);
      check({tag, "_wbv_pulse"}, 32'(wb_valid), 32'd0);
      check({tag, "_data_hold"}, wb_load_data, exp);
      tick();
   endtask

   initial begin
      rst = 1'b0; m_valid = 1'b0; m_valid_t = 1'b0;
      m_mem_read = 1'b0; m_mem_write = 1'b0; m_funct3 = 3'b000;
      m_alu_out = '0; m_rs2_data = '0;
      bus.dm_gnt = 1'b0; bus.dm_rvalid = 1'b0; bus.dm_rdata = '0;
      bus_t.dm_gnt = 1'b0; bus_t.dm_rvalid = 1'b0; bus_t.dm_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_req", 32'(bus.dm_req), 32'd0);
      check("rst_stall", 32'(lsu_stall), 32'd0);
      check("rst_wbv", 32'(wb_valid), 32'd0);
      check("rst_data", wb_load_data, 32'd0);
      check("rst_addr", bus.dm_addr, 32'd0);
      check("rst_wstrb", 32'(bus.dm_wstrb), 32'd0);
      check("rst_berr", 32'(bus_err), 32'd0);
      tick();
      rst = 1'b1;
      tick();

      store_op(3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, "sw");
      load_op(3'b000, 32'h203, 32'h80FF1234, 32'hFFFFFF80, "lb");
      load_op(3'b100, 32'h203, 32'h80FF1234, 32'h00000080, "lbu");
      store_op(3'b001, 32'h42, 32'h0000A5C3, 32'hA5C3A5C3, 4'b1100, "sh");
      load_op(3'b101, 32'h42, 32'hA5C30000, 32'h0000A5C3, "lhu");

      m_valid = 1'b1; m_mem_read = 1'b1; m_funct3 = 3'b010;
      m_alu_out = 32'h101;
      @(negedge clk);
      check("lw_mis", 32'(misalign), 32'd1);
      check("lw_mis_stall", 32'(lsu_stall), 32'd0);
      check("lw_mis_req", 32'(bus.dm_req), 32'd0);
      tick();
      m_valid = 1'b0; m_mem_read = 1'b0;
      @(negedge clk);
      check("lw_mis_pulse", 32'(misalign), 32'd0);
      check("lw_mis_req2", 32'(bus.dm_req), 32'd0);
      tick();

      m_valid = 1'b1; m_mem_write = 1'b1; m_funct3 = 3'b001;
      m_alu_out = 32'h41;
      @(negedge clk);
      check("sh_mis", 32'(misalign), 32'd1);
      check("sh_mis_stall", 32'(lsu_stall), 32'd0);
      tick();
      m_valid = 1'b0; m_mem_write = 1'b0;
      @(negedge clk);
      check("sh_mis_req", 32'(bus.dm_req), 32'd0);
      tick();

      m_valid = 1'b1; m_funct3 = 3'b010; m_alu_out = 32'h101;
      @(negedge clk);
      check("nop_mis", 32'(misalign), 32'd0);
      check("nop_stall", 32'(lsu_stall), 32'd0);
      tick();
      @(negedge clk);
      check("nop_req", 32'(bus.dm_req), 32'd0);
      m_valid = 1'b0;
      tick();

      // Give the short-budget instance a non-zero load result first.
      m_valid_t = 1'b1; m_mem_read = 1'b1; m_funct3 = 3'b010;
      m_alu_out = 32'h300;
      tick();
      bus_t.dm_gnt = 1'b1;
      tick();
      bus_t.dm_gnt = 1'b0; bus_t.dm_rvalid = 1'b1;
      bus_t.dm_rdata = 32'h12345678;
      tick();
      bus_t.dm_rvalid = 1'b0;
      @(negedge clk);
      check("tp_wbv", 32'(t_valid), 32'd1);
      check("tp_data", t_data, 32'h12345678);
      tick();
      m_valid_t = 1'b0;
      tick();

      m_valid_t = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("to_req", 32'(bus_t.dm_req), 32'd1);
         check("to_berr_early", 32'(t_err), 32'd0);
         check("to_stall", 32'(t_stall), 32'd1);
         tick();
      end
      @(negedge clk);
      check("to_wbv", 32'(t_valid), 32'd1);
      check("to_berr", 32'(t_err), 32'd1);
      check("to_data", t_data, 32'd0);
      check("to_done_stall", 32'(t_stall), 32'd0);
      tick();
      m_valid_t = 1'b0; m_mem_read = 1'b0;
      @(negedge clk);
      check("to_berr_pulse", 32'(t_err), 32'd0);
      check("to_wbv_pulse", 32'(t_valid), 32'd0);
      tick();

      m_valid = 1'b1; m_mem_read = 1'b1; m_funct3 = 3'b010;
      m_alu_out = 32'h400; bus.dm_gnt = 1'b1;
      @(negedge clk);
      check("rw_c0_stall", 32'(lsu_stall), 32'd1);
      tick();
      @(negedge clk);
      check("rw_req", 32'(bus.dm_req), 32'd1);
      tick();
      bus.dm_gnt = 1'b0; m_valid = 1'b0; m_mem_read = 1'b0; rst = 1'b0;
      @(negedge clk);
      check("rw_wait_stall", 32'(lsu_stall), 32'd1);
      tick();
      rst = 1'b1; bus.dm_rvalid = 1'b1; bus.dm_rdata = 32'hCAFEF00D;
      @(negedge clk);
      check("rw_req_drop", 32'(bus.dm_req), 32'd0);
      check("rw_stall", 32'(lsu_stall), 32'd0);
      check("rw_wbv", 32'(wb_valid), 32'd0);
      check("rw_data", wb_load_data, 32'd0);
      check("rw_addr", bus.dm_addr, 32'd0);
      tick();
      bus.dm_rvalid = 1'b0;
      @(negedge clk);
      check("rw_late_wbv", 32'(wb_valid), 32'd0);
      check("rw_late_data", wb_load_data, 32'd0);
      tick();

      store_op(3'b000, 32'h201, 32'h12345677, 32'h77777777, 4'b0010, "sb");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the memory stage of the pipeline CPU. It consumes the M-stage pipeline register outputs (ALU result as the effective address, rs2 data as store data) plus memory control bits. It runs a request/grant/response handshake with the data memory, stalls the pipeline while an access is outstanding, and delivers an aligned, sign/zero-extended load result toward write-back.

## Interface
- TIMEOUT_CYCLES, 255: cycles allowed in REQ+WAIT before the access is aborted with bus_err (8-bit counter, range 1..255).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset (rst=0 sampled at posedge resets the block).
- m_valid  input  1  valid instruction present in M stage.
- m_mem_read  input  1  instruction is a load.
- m_mem_write  input  1  instruction is a store; wins if both are set.
- m_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are treated as W.
- m_alu_out  input  32  effective byte address.
- m_rs2_data  input  32  store data.
- dm_req  output  1  memory request, held until grant.
- dm_we  output  1  1 = write.
- dm_addr  output  32  word address {addr[31:2],2'b00}.
- dm_wdata  output  32  lane-replicated store data.
- dm_wstrb  output  4  byte enables (0000 for loads).
- dm_gnt  input  1  memory accepts request this cycle.
- dm_rvalid  input  1  read data valid.
- dm_rdata  input  32  read word.
- lsu_stall  output  1  freeze M stage and all upstream stages.
- wb_valid  output  1  one-cycle completion pulse.
- wb_load_data  output  32  extended load result, held until the next load completes.
- misalign  output  1  misaligned-access pulse (combinational).
- bus_err  output  1  timeout pulse.

## Operation
- States: IDLE, REQ, WAIT, DONE. A memory op is m_valid & (m_mem_read | m_mem_write).
- IDLE, aligned memory op: latch address, we, funct3, wdata, and wstrb; go to REQ; lsu_stall=1.
- IDLE, misaligned op (H/HU/SH with addr[0]=1; W/SW with addr[1:0]≠0): misalign=1, no request, lsu_stall=0, stay in IDLE.
- REQ: dm_req=1 with stable latched fields. On dm_gnt, stores go to DONE and loads go to WAIT.
- WAIT: on dm_rvalid, extract and extend the lane, write wb_load_data, go to DONE.
- DONE: wb_valid=1, lsu_stall=0, go to IDLE. The pipeline advances on this edge.
- Timeout: the counter clears on entry to REQ and increments each REQ/WAIT cycle. When it reaches TIMEOUT_CYCLES, go to DONE with bus_err=1 in that DONE cycle; a timed-out load writes wb_load_data=0.
- Store lanes:
  - SB replicates rs2[7:0] to all four lanes; wstrb = 0001 << addr[1:0].
  - SH replicates rs2[15:0] to both halves; wstrb = 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - SW sends rs2 unchanged; wstrb = 1111.
- Load extraction: byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16]. B/H sign-extend, BU/HU zero-extend, W passes through.
- lsu_stall = (IDLE & aligned memory op) | REQ | WAIT.
- Non-memory instructions in IDLE: no stall, no outputs asserted.
- dm_rvalid in IDLE, REQ, or DONE is ignored. dm_gnt outside REQ is ignored.

## Timing
- Reset values: state IDLE; dm_req, dm_we, wb_valid, bus_err, lsu_stall (registered part) = 0; dm_addr, dm_wdata, wb_load_data = 0; dm_wstrb = 0000; counter = 0.
- rst=0 in any state returns the block to IDLE at that edge. An outstanding request is dropped (dm_req=0 the next cycle), and any late dm_rvalid is ignored.
- Store with immediate grant: cycle 0 IDLE (stall), cycle 1 REQ+gnt, cycle 2 DONE (wb_valid). 3 cycles total, 2 stall cycles.
- Load with gnt in cycle 1 and rvalid in cycle 2: DONE in cycle 3. wb_load_data is valid from cycle 3.
- dm_req stays high across gnt=0 cycles, with dm_addr, dm_wdata, and dm_wstrb constant.
- gnt and rvalid in the same cycle during REQ: the rvalid is ignored. Load data is accepted only in WAIT.
- wb_valid and bus_err last exactly one cycle. misalign is high only while a misaligned op is presented in IDLE.

## Test plan
- SW addr 0x100, rs2 0xDEADBEEF, gnt on first REQ cycle: expect dm_addr=0x100, wstrb=1111, wdata=0xDEADBEEF; wb_valid in cycle 2; lsu_stall high in cycles 0–1.
- LB addr 0x203, rdata 0x80FF1234 after 3 gnt-low cycles then rvalid: expect wb_load_data=0xFFFFFF80. Repeat with LBU: expect 0x00000080.
- SH addr 0x42, rs2 0x0000A5C3: expect wdata=0xA5C3A5C3, wstrb=1100. LHU addr 0x42 with rdata 0xA5C30000: expect 0x0000A5C3.
- LW addr 0x101: expect misalign=1 for 1 cycle, dm_req never asserted, lsu_stall=0.
- TIMEOUT_CYCLES=4, dm_gnt held at 0: expect DONE with bus_err=1 four cycles after entering REQ, and wb_load_data=0.
- rst=0 asserted while in WAIT, then rvalid arrives: expect IDLE, all outputs 0, rvalid ignored, and a subsequent SB completes normally.
